// File: rtl/pu_array_controller_pkg.sv
// Shared types for the PU array controller: state encoding and width constants.
package pu_array_controller_pkg;

    localparam int unsigned STATE_BITS = 3;

    typedef enum logic [STATE_BITS-1:0] {
        StIdle    = 3'd0,
        StLoadB   = 3'd1,
        StLoadA   = 3'd2,
        StMult    = 3'd3,
        StAdd     = 3'd4,
        StUpdateA = 3'd5,
        StFindRes = 3'd6,
        StDone    = 3'd7
    } state_e;

endpackage

// File: rtl/pu_prio_enc.sv
// Lowest-index priority encoder over the PU zero flags.
module pu_prio_enc #(
    parameter int unsigned NUM_PU = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic [NUM_PU-1:0] z,
    output logic              valid,
    output logic [SEL_W-1:0]  idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_PU - 1; i >= 0; i--) begin
            if (z[i]) begin
                valid = 1'b1;
                idx   = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/pu_array_controller.sv
// Sequencer for the PU datapath: load/multiply/accumulate/update loop with iteration count,
// priority result select and start/done/ack handshake.
module pu_array_controller
    import pu_array_controller_pkg::*;
#(
    parameter int unsigned NUM_PU = 4,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ack,
    input  logic [ITER_W-1:0] iter_lim,
    input  logic              end_signal,
    input  logic [NUM_PU-1:0] z,
    output logic              b_regs_en,
    output logic              a_regs_en,
    output logic              a_muxs,
    output logic              pu_mult_regs_en,
    output logic              pu_add_regs_en,
    output logic [SEL_W-1:0]  res_sel,
    output logic              res_valid,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
    logic [ITER_W-1:0] iter_lim_q, iter_lim_d;
    logic [SEL_W-1:0]  res_sel_q;
    logic              res_valid_q;
    logic              res_load;
    logic [SEL_W-1:0]  enc_idx;
    logic              enc_valid;

    pu_prio_enc #(
        .NUM_PU(NUM_PU),
        .SEL_W (SEL_W)
    ) u_prio_enc (
        .z    (z),
        .valid(enc_valid),
        .idx  (enc_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            iter_cnt_q  <= '0;
            iter_lim_q  <= '0;
            res_sel_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
            iter_lim_q <= iter_lim_d;
            if (res_load) begin
                res_sel_q   <= enc_idx;
                res_valid_q <= enc_valid;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        iter_cnt_d      = iter_cnt_q;
        iter_lim_d      = iter_lim_q;
        res_load        = 1'b0;
        b_regs_en       = 1'b0;
        a_regs_en       = 1'b0;
        a_muxs          = 1'b0;
        pu_mult_regs_en = 1'b0;
        pu_add_regs_en  = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    iter_lim_d = iter_lim;
                    iter_cnt_d = '0;
                    state_d    = StLoadB;
                end
            end
            StLoadB: begin
                b_regs_en = 1'b1;
                state_d   = StLoadA;
            end
            StLoadA: begin
                a_regs_en = 1'b1;
                a_muxs    = 1'b1;
                state_d   = StMult;
            end
            StMult: begin
                pu_mult_regs_en = 1'b1;
                state_d         = StAdd;
            end
            StAdd: begin
                pu_add_regs_en = 1'b1;
                state_d        = StUpdateA;
            end
            StUpdateA: begin
                a_regs_en = 1'b1;
                // Exit on equality so the counter never wraps, even at the maximum limit.
                if (end_signal || (iter_cnt_q == iter_lim_q)) begin
                    state_d = StFindRes;
                end else begin
                    iter_cnt_d = iter_cnt_q + ITER_W'(1);
                    state_d    = StMult;
                end
            end
            StFindRes: begin
                res_load = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                done = 1'b1;
                if (ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                busy    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    assign res_sel   = res_sel_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_pu_array_controller.sv
// Scoreboard bench for pu_array_controller: directed runs, per-cycle enable trace and
// result/latency checks, plus an 8-PU instance for the wide encoder.
module tb_pu_array_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       ack = 1'b0;
    logic       end_signal = 1'b0;
    logic [7:0] iter_lim = 8'd0;
    logic [3:0] z = 4'd0;
    logic       b_regs_en, a_regs_en, a_muxs, pu_mult_regs_en, pu_add_regs_en;
    logic [1:0] res_sel;
    logic       res_valid, busy, done;

    logic       start8 = 1'b0;
    logic       ack8 = 1'b0;
    logic       end8 = 1'b0;
    logic [7:0] lim8 = 8'd0;
    logic [7:0] z8 = 8'd0;
    logic       b8, a8, mux8, mult8, add8;
    logic [2:0] res_sel8;
    logic       res_valid8, busy8, done8;

    pu_array_controller #(
        .NUM_PU(4),
        .SEL_W (2),
        .ITER_W(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .ack            (ack),
        .iter_lim       (iter_lim),
        .end_signal     (end_signal),
        .z              (z),
        .b_regs_en      (b_regs_en),
        .a_regs_en      (a_regs_en),
        .a_muxs         (a_muxs),
        .pu_mult_regs_en(pu_mult_regs_en),
        .pu_add_regs_en (pu_add_regs_en),
        .res_sel        (res_sel),
        .res_valid      (res_valid),
        .busy           (busy),
        .done           (done)
    );

    pu_array_controller #(
        .NUM_PU(8),
        .SEL_W (3),
        .ITER_W(8)
    ) dut8 (
        .clk            (clk),
        .rst            (rst),
        .start          (start8),
        .ack            (ack8),
        .iter_lim       (lim8),
        .end_signal     (end8),
        .z              (z8),
        .b_regs_en      (b8),
        .a_regs_en      (a8),
        .a_muxs         (mux8),
        .pu_mult_regs_en(mult8),
        .pu_add_regs_en (add8),
        .res_sel        (res_sel8),
        .res_valid      (res_valid8),
        .busy           (busy8),
        .done           (done8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int lat;
        int sel;
        int valid;
    } res_t;

    res_t       res_q[$];
    logic [4:0] trace_q[$];
    int         st_cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       done_prev = 1'b0;

    localparam logic [4:0] EnB = 5'b10000;
    localparam logic [4:0] EnA = 5'b01100;
    localparam logic [4:0] EnM = 5'b00010;
    localparam logic [4:0] EnD = 5'b00001;
    localparam logic [4:0] EnU = 5'b01000;
    localparam logic [4:0] EnF = 5'b00000;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle enable trace while running, result/latency on the rising edge of done.
    always @(negedge clk) begin
        if (!rst) begin
            done_prev <= 1'b0;
        end else begin
            if (busy && !done) begin
                if (trace_q.size() == 0) begin
                    check("trace_underflow", 1, 0);
                end else begin
                    check("enables", {b_regs_en, a_regs_en, a_muxs, pu_mult_regs_en,
                                      pu_add_regs_en}, trace_q[0]);
                    void'(trace_q.pop_front());
                end
            end
            if (done && !done_prev) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("latency", cyc - st_cyc, res_q[0].lat);
                    check("res_sel", res_sel, res_q[0].sel);
                    check("res_valid", res_valid, res_q[0].valid);
                    void'(res_q.pop_front());
                end
            end
            done_prev <= done;
        end
    end

    task automatic expect_run(input int passes, input int sel, input int valid);
        res_t e;
        e.lat   = 4 + 3 * passes;
        e.sel   = sel;
        e.valid = valid;
        res_q.push_back(e);
        trace_q.push_back(EnB);
        trace_q.push_back(EnA);
        for (int p = 0; p < passes; p++) begin
            trace_q.push_back(EnM);
            trace_q.push_back(EnD);
            trace_q.push_back(EnU);
        end
        trace_q.push_back(EnF);
    endtask

    // Start held for one cycle; iter_lim is scrambled afterwards since only the capture counts.
    task automatic launch(input logic [7:0] lim, input logic [3:0] zval);
        @(negedge clk);
        iter_lim = lim;
        z        = zval;
        start    = 1'b1;
        st_cyc   = cyc;
        @(negedge clk);
        start    = 1'b0;
        iter_lim = ~lim;
    endtask

    task automatic wait_until(input int at);
        while (cyc < st_cyc + at) @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, done, 1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic run8(input logic [7:0] zval, input int sel, input int valid);
        int n = 0;
        @(negedge clk);
        z8     = zval;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        while (!done8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("w8_done", done8, 1);
        check("w8_res_sel", res_sel8, sel);
        check("w8_res_valid", res_valid8, valid);
        ack8 = 1'b1;
        @(negedge clk);
        ack8 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("reset_outs", {b_regs_en, a_regs_en, a_muxs, pu_mult_regs_en, pu_add_regs_en,
                             res_sel, res_valid, busy, done}, 0);
        check("reset_outs8", {b8, a8, mux8, mult8, add8, res_sel8, res_valid8, busy8, done8}, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single pass, z=0100 -> index 2.
        expect_run(1, 2, 1);
        launch(8'd0, 4'b0100);
        wait_done("t1");
        do_ack();

        // Four passes; end_signal pulsed in MULT must be ignored.
        expect_run(4, 3, 1);
        launch(8'd3, 4'b1000);
        wait_until(3);
        end_signal = 1'b1;
        @(negedge clk);
        end_signal = 1'b0;
        wait_done("t2");
        do_ack();

        // Early exit in the second UPDATE_A.
        expect_run(2, 1, 1);
        launch(8'd10, 4'b0110);
        wait_until(8);
        end_signal = 1'b1;
        @(negedge clk);
        end_signal = 1'b0;
        wait_done("t3");
        do_ack();

        // Lowest set bit wins; result holds through DONE and IDLE despite z changing.
        expect_run(1, 1, 1);
        launch(8'd0, 4'b1010);
        wait_done("t4a");
        z = 4'b0000;
        @(negedge clk);
        check("hold_done_sel", res_sel, 1);
        do_ack();
        repeat (2) @(negedge clk);
        check("hold_idle_sel", res_sel, 1);
        check("hold_idle_valid", res_valid, 1);

        expect_run(1, 0, 0);
        launch(8'd0, 4'b0000);
        wait_done("t4b");
        do_ack();
        z = 4'b0010;
        repeat (2) @(negedge clk);
        check("hold_invalid", res_valid, 0);

        // Start ignored in MULT and DONE; ack held off for 5 cycles; start+ack -> IDLE only.
        expect_run(1, 2, 1);
        launch(8'd0, 4'b0100);
        wait_until(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5");
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("done_held", done, 1);
        end
        start = 1'b1;
        ack   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ack   = 1'b0;
        check("busy_after_ack", busy, 0);
        @(negedge clk);
        check("no_restart", busy, 0);
        check("done_after_ack", done, 0);

        // Maximum limit: counter exits at equality, 256 passes.
        expect_run(256, 2, 1);
        launch(8'd255, 4'b1100);
        wait_done("tmax");
        do_ack();

        // Reset during ADD: immediate IDLE, result cleared, then a clean run.
        trace_q.push_back(EnB);
        trace_q.push_back(EnA);
        trace_q.push_back(EnM);
        trace_q.push_back(EnD);
        launch(8'd1, 4'b0100);
        wait_until(4);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_outs", {b_regs_en, a_regs_en, a_muxs, pu_mult_regs_en, pu_add_regs_en,
                               res_sel, res_valid, busy, done}, 0);
        check("rst_mid_trace", trace_q.size(), 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        expect_run(2, 1, 1);
        launch(8'd1, 4'b0010);
        wait_done("t6");
        do_ack();

        run8(8'h80, 7, 1);
        run8(8'h24, 2, 1);
        run8(8'h00, 0, 0);

        repeat (2) @(negedge clk);
        check("res_q_empty", res_q.size(), 0);
        check("trace_q_empty", trace_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
